softmax_ctrl: RTL and testbench
===============================

Name: softmax_ctrl

Overview:
Sequencer for one softmax row over NUM_OF_NODES attention coefficients, placed between the attention-coefficient stage and the aggregation stage.
- Captures a flattened coefficient row and finds the row maximum.
- Issues each (coef - max) to an external exponent unit and accumulates the sum.
- Issues each exp/sum to an external divider and assembles the flattened alpha row for downstream.

Parameters:
DATA_WIDTH, 8, coef/alpha element width; coef signed two's complement, alpha unsigned fraction
NUM_OF_NODES, 5, elements per row
EXP_WIDTH, 12, exponent-unit result width (unsigned)
SUM_WIDTH, EXP_WIDTH+$clog2(NUM_OF_NODES), accumulator width (derived localparam)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
sm_valid_i  in  1  coefficient row valid
sm_ready_o  out  1  controller can accept a row
coef_i  in  NUM_OF_NODES*DATA_WIDTH  row, element 0 in MSBs
exp_req_o  out  1  exponent request
exp_x_o  out  DATA_WIDTH  signed argument, always <= 0
exp_ack_i  in  1  exponent result valid (consumes request)
exp_y_i  in  EXP_WIDTH  exponent result
div_req_o  out  1  divide request
div_num_o  out  EXP_WIDTH  numerator
div_den_o  out  SUM_WIDTH  denominator
div_ack_i  in  1  quotient valid (consumes request)
div_q_i  in  DATA_WIDTH  quotient
alpha_valid_o  out  1  alpha row valid
alpha_ready_i  in  1  downstream accepts row
alpha_o  out  NUM_OF_NODES*DATA_WIDTH  alpha row, element 0 in MSBs

Behaviour:
- Reset: state IDLE, counters/regs cleared.
  - Outputs: sm_ready_o=1; all req/valid outputs 0; exp_x_o, div_num_o, div_den_o, alpha_o all 0.
  - rst asserted in any state aborts the row, discards any ack, and returns to IDLE next cycle.
- FSM: IDLE -> MAX -> EXP -> DIV -> OUT -> IDLE.
- IDLE: sm_ready_o=1 only here.
  - On sm_valid_i, register coef_i into coef[0..N-1], set max=coef[0], idx=1, go MAX.
- MAX: one element per cycle, signed compare, max=larger.
  - After idx=N-1, go EXP with idx=0 and sum=0.
  - Takes N-1 cycles; with N=1 go straight to EXP.
- EXP: exp_req_o held high with exp_x_o = sat(coef[idx]-max).
  - Subtraction is DATA_WIDTH+1 bits, saturated to -2^(DATA_WIDTH-1).
  - exp_req_o/exp_x_o change only after exp_ack_i. An ack while req is low is ignored.
  - On ack: e[idx]=exp_y_i, sum+=exp_y_i (no overflow by construction), idx++.
  - After the last ack, drop req and go DIV with idx=0.
- DIV: if sum==0, issue no requests; alpha all 0; go OUT.
  - Otherwise div_req_o held high with div_num_o=e[idx], div_den_o=sum.
  - On div_ack_i: alpha[idx]=div_q_i, idx++. After the last ack, go OUT.
- OUT: alpha_valid_o=1 and alpha_o stable until alpha_ready_i.
  - The handshake cycle returns to IDLE; sm_ready_o rises the following cycle, so there is a one-cycle bubble between rows.
- Acks may arrive in the same cycle as a request; min latency per element is 1 cycle.
- Controller output is the exp/div request and alpha_valid_o; request inputs are ignored except in their own state.

Optional Feature:
SOFTMAX_CTRL_MASK_EN
- Defined: adds input port mask_i [NUM_OF_NODES], captured with coef_i in IDLE (bit i = element i, 1 = neighbour absent).
  - Masked elements are excluded from MAX, skip EXP/DIV requests, and get e=0 and alpha=0.
  - MAX initialises from the first unmasked element.
  - All masked: no requests at all; sum=0; alpha all 0.
- Undefined: no mask_i port; every element is processed.

Decomposition:
- Package softmax_pkg holds:
  - state enum (IDLE, MAX, EXP, DIV, OUT);
  - SUM_WIDTH derivation function;
  - the saturating signed subtract function.
- Flatten/deflatten stays inline.
- One natural sub-module: softmax_rowbuf, holding the coef/e/alpha register arrays with indexed write and flattened read.

Test Plan:
- Row all 0, bench exp model y=2048>>(-x), divider q=floor(num*128/den), immediate acks.
  - Expect 5 exp requests with x=0, sum=10240, 5 div requests 2048/10240.
  - Expect alpha_o = 5×25 and alpha_valid_o asserted exactly 1 cycle after the last div ack.
- Row {3,1,-128,3,0}.
  - Expect max=3 and exp_x sequence {0,-2,-128(saturated),0,-3}.
- Random ack delays 0–7 cycles with alpha_ready_i low for 10 cycles.
  - Request args stable while pending; alpha_o stable; sm_ready_o low until 1 cycle after the handshake.
- rst pulsed mid-EXP with an ack in the same cycle.
  - Next cycle: IDLE, all outputs at reset values, sum/e cleared; a following row completes correctly.
- Back-to-back rows with sm_valid_i held high.
  - Second row is captured exactly 1 cycle after the first alpha handshake.
- With SOFTMAX_CTRL_MASK_EN: mask=5'b11111 -> zero exp/div requests, alpha all 0; mask=5'b10001 -> 3 exp requests, alpha[0]=alpha[4]=0.

Source files
------------

// File: rtl/softmax_pkg.sv
// Shared state encoding and arithmetic helpers for the softmax row sequencer.
package softmax_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StMax  = 3'd1;
  localparam state_t StExp  = 3'd2;
  localparam state_t StDiv  = 3'd3;
  localparam state_t StOut  = 3'd4;

  // Wide enough to hold the sum of n exponent results without overflow.
  function automatic int unsigned sum_width(input int unsigned exp_w, input int unsigned n);
    return exp_w + $clog2(n);
  endfunction

  // a - b computed wide; a never exceeds b here, so only the low bound can be crossed.
  function automatic int sat_sub(input int a, input int b, input int unsigned w);
    int diff;
    int lo;
    diff = a - b;
    lo   = -(1 <<< (w - 1));
    return (diff < lo) ? lo : diff;
  endfunction

endpackage

// File: rtl/softmax_rowbuf.sv
// Per-row register arrays: captured coefficients, exponent results and alpha outputs.
module softmax_rowbuf
  import softmax_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned NUM_OF_NODES = 5,
  parameter int unsigned EXP_WIDTH    = 12,
  parameter int unsigned IDX_WIDTH    = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load_i,
  input  logic [NUM_OF_NODES*DATA_WIDTH-1:0] coef_i,
  input  logic [IDX_WIDTH-1:0]               idx_i,
  input  logic                               e_we_i,
  input  logic [EXP_WIDTH-1:0]               e_i,
  input  logic                               alpha_we_i,
  input  logic [DATA_WIDTH-1:0]              alpha_i,
  output logic [DATA_WIDTH-1:0]              coef_o,
  output logic [EXP_WIDTH-1:0]               e_o,
  output logic [NUM_OF_NODES*DATA_WIDTH-1:0] alpha_o
);

  logic [DATA_WIDTH-1:0] coef_q  [NUM_OF_NODES];
  logic [EXP_WIDTH-1:0]  e_q     [NUM_OF_NODES];
  logic [DATA_WIDTH-1:0] alpha_q [NUM_OF_NODES];

  // Loading a new row also clears e/alpha so skipped elements read back as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_OF_NODES); i++) begin
        coef_q[i]  <= '0;
        e_q[i]     <= '0;
        alpha_q[i] <= '0;
      end
    end else if (load_i) begin
      for (int i = 0; i < int'(NUM_OF_NODES); i++) begin
        coef_q[i]  <= coef_i[(NUM_OF_NODES-1-i)*DATA_WIDTH +: DATA_WIDTH];
        e_q[i]     <= '0;
        alpha_q[i] <= '0;
      end
    end else begin
      if (e_we_i) e_q[idx_i] <= e_i;
      if (alpha_we_i) alpha_q[idx_i] <= alpha_i;
    end
  end

  assign coef_o = coef_q[idx_i];
  assign e_o    = e_q[idx_i];

  always_comb begin
    alpha_o = '0;
    for (int i = 0; i < int'(NUM_OF_NODES); i++) begin
      alpha_o[(NUM_OF_NODES-1-i)*DATA_WIDTH +: DATA_WIDTH] = alpha_q[i];
    end
  end

endmodule

// File: rtl/softmax_ctrl.sv
// Softmax row sequencer: max search, exponent requests with summation, then per-element divide.
// Optional SOFTMAX_CTRL_MASK_EN adds mask_i to exclude absent neighbours from the row.
module softmax_ctrl
  import softmax_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned NUM_OF_NODES = 5,
  parameter int unsigned EXP_WIDTH    = 12,
  localparam int unsigned SUM_WIDTH   = sum_width(EXP_WIDTH, NUM_OF_NODES)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               sm_valid_i,
  output logic                               sm_ready_o,
  input  logic [NUM_OF_NODES*DATA_WIDTH-1:0] coef_i,
`ifdef SOFTMAX_CTRL_MASK_EN
  input  logic [NUM_OF_NODES-1:0]            mask_i,
`endif
  output logic                               exp_req_o,
  output logic [DATA_WIDTH-1:0]              exp_x_o,
  input  logic                               exp_ack_i,
  input  logic [EXP_WIDTH-1:0]               exp_y_i,
  output logic                               div_req_o,
  output logic [EXP_WIDTH-1:0]               div_num_o,
  output logic [SUM_WIDTH-1:0]               div_den_o,
  input  logic                               div_ack_i,
  input  logic [DATA_WIDTH-1:0]              div_q_i,
  output logic                               alpha_valid_o,
  input  logic                               alpha_ready_i,
  output logic [NUM_OF_NODES*DATA_WIDTH-1:0] alpha_o
);

  localparam int unsigned IdxW = (NUM_OF_NODES > 1) ? $clog2(NUM_OF_NODES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_OF_NODES - 1);

  state_t                        state_q, state_d;
  logic [IdxW-1:0]               idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0]  max_q, max_d;
  logic [SUM_WIDTH-1:0]          sum_q, sum_d;
  logic [NUM_OF_NODES-1:0]       mask_q, mask_d, mask_in;
  logic signed [DATA_WIDTH-1:0]  first_val;
  logic [DATA_WIDTH-1:0]         coef_rd;
  logic [EXP_WIDTH-1:0]          e_rd;
  logic                          load, e_we, alpha_we, cur_masked;

`ifdef SOFTMAX_CTRL_MASK_EN
  assign mask_in = mask_i;
`else
  assign mask_in = '0;
`endif

  assign cur_masked = mask_q[idx_q];

  // Lowest-index unmasked element seeds the max search.
  always_comb begin
    first_val = coef_i[NUM_OF_NODES*DATA_WIDTH-1 -: DATA_WIDTH];
    for (int i = int'(NUM_OF_NODES) - 1; i >= 0; i--) begin
      if (!mask_in[i]) first_val = coef_i[(NUM_OF_NODES-1-i)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    max_d    = max_q;
    sum_d    = sum_q;
    mask_d   = mask_q;
    load     = 1'b0;
    e_we     = 1'b0;
    alpha_we = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sm_valid_i) begin
          load   = 1'b1;
          mask_d = mask_in;
          max_d  = first_val;
          sum_d  = '0;
          if (NUM_OF_NODES == 1) begin
            state_d = StExp;
            idx_d   = '0;
          end else begin
            state_d = StMax;
            idx_d   = IdxW'(1);
          end
        end
      end
      StMax: begin
        if (!cur_masked && ($signed(coef_rd) > max_q)) max_d = coef_rd;
        if (idx_q == LastIdx) begin
          state_d = StExp;
          idx_d   = '0;
          sum_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StExp: begin
        // Masked elements advance without a request.
        if (cur_masked || exp_ack_i) begin
          if (!cur_masked) begin
            e_we  = 1'b1;
            sum_d = sum_q + SUM_WIDTH'(exp_y_i);
          end
          if (idx_q == LastIdx) begin
            state_d = StDiv;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDiv: begin
        if (sum_q == '0) begin
          state_d = StOut;
        end else if (cur_masked || div_ack_i) begin
          alpha_we = !cur_masked;
          if (idx_q == LastIdx) begin
            state_d = StOut;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StOut: begin
        if (alpha_ready_i) begin
          state_d = StIdle;
          idx_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      max_q   <= '0;
      sum_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
      mask_q  <= mask_d;
    end
  end

  softmax_rowbuf #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_OF_NODES(NUM_OF_NODES),
    .EXP_WIDTH   (EXP_WIDTH),
    .IDX_WIDTH   (IdxW)
  ) u_rowbuf (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .coef_i    (coef_i),
    .idx_i     (idx_q),
    .e_we_i    (e_we),
    .e_i       (exp_y_i),
    .alpha_we_i(alpha_we),
    .alpha_i   (div_q_i),
    .coef_o    (coef_rd),
    .e_o       (e_rd),
    .alpha_o   (alpha_o)
  );

  assign sm_ready_o    = (state_q == StIdle);
  assign alpha_valid_o = (state_q == StOut);
  assign exp_req_o     = (state_q == StExp) && !cur_masked;
  assign div_req_o     = (state_q == StDiv) && (sum_q != '0) && !cur_masked;

  assign exp_x_o   = exp_req_o ?
                     DATA_WIDTH'(sat_sub(int'($signed(coef_rd)), int'(max_q), DATA_WIDTH)) : '0;
  assign div_num_o = div_req_o ? e_rd : '0;
  assign div_den_o = div_req_o ? sum_q : '0;

endmodule

// File: tb/tb_softmax_ctrl.sv
// Self-checking bench for softmax_ctrl with behavioural exponent/divider units and a row model.
module tb_softmax_ctrl;

  localparam int N  = 5;
  localparam int DW = 8;
  localparam int EW = 12;
  localparam int SW = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            sm_valid_i = 1'b0;
  logic            sm_ready_o;
  logic [N*DW-1:0] coef_i = '0;
  logic [N-1:0]    mask_i = '0;
  logic            exp_req_o;
  logic [DW-1:0]   exp_x_o;
  logic            exp_ack_i = 1'b0;
  logic [EW-1:0]   exp_y_i = '0;
  logic            div_req_o;
  logic [EW-1:0]   div_num_o;
  logic [SW-1:0]   div_den_o;
  logic            div_ack_i = 1'b0;
  logic [DW-1:0]   div_q_i = '0;
  logic            alpha_valid_o;
  logic            alpha_ready_i = 1'b1;
  logic [N*DW-1:0] alpha_o;

  always #5 clk = ~clk;

  softmax_ctrl #(
    .DATA_WIDTH  (DW),
    .NUM_OF_NODES(N),
    .EXP_WIDTH   (EW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sm_valid_i   (sm_valid_i),
    .sm_ready_o   (sm_ready_o),
    .coef_i       (coef_i),
`ifdef SOFTMAX_CTRL_MASK_EN
    .mask_i       (mask_i),
`endif
    .exp_req_o    (exp_req_o),
    .exp_x_o      (exp_x_o),
    .exp_ack_i    (exp_ack_i),
    .exp_y_i      (exp_y_i),
    .div_req_o    (div_req_o),
    .div_num_o    (div_num_o),
    .div_den_o    (div_den_o),
    .div_ack_i    (div_ack_i),
    .div_q_i      (div_q_i),
    .alpha_valid_o(alpha_valid_o),
    .alpha_ready_i(alpha_ready_i),
    .alpha_o      (alpha_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // External units as the controller's neighbours would implement them.
  function automatic logic [EW-1:0] exp_unit(input logic [DW-1:0] x);
    int s;
    s = -int'($signed(x));
    return EW'(2048 >> s);
  endfunction

  function automatic logic [DW-1:0] div_unit(input logic [EW-1:0] num, input logic [SW-1:0] den);
    if (den == '0) return '0;
    return DW'((int'(num) * 128) / int'(den));
  endfunction

  // ---------------- row model ----------------
  logic [N*DW-1:0] row_q[$];
  logic [N-1:0]    rmask_q[$];
  logic [DW-1:0]   xq[$];
  logic [EW-1:0]   numq[$];
  logic [DW-1:0]   xlog[$];
  logic [SW-1:0]   den_m;
  logic [N*DW-1:0] alpha_m;
  bit              sum0;
  int              phase = 0;  // 0 idle, 1 busy, 2 row presented
  int              cyc = 0, cap_cnt = 0, hs_cnt = 0, exp_hs = 0, div_hs = 0;
  int              cap_cyc = 0, hs_cyc = 0, last_div_cyc = 0, valid_cyc = 0;
  logic [SW-1:0]   last_den = '0;
  logic [N*DW-1:0] last_alpha = '0;
  bit              prev_valid = 1'b0;
  bit              rand_dly = 1'b0;

  task automatic build_model(input logic [N*DW-1:0] r, input logic [N-1:0] m);
    int c[N];
    int e[N];
    int mx, x, sum, a;
    mx = -1000;
    sum = 0;
    for (int i = 0; i < N; i++) begin
      c[i] = int'($signed(r[(N-1-i)*DW +: DW]));
      if (!m[i] && c[i] > mx) mx = c[i];
    end
    xq.delete();
    numq.delete();
    for (int i = 0; i < N; i++) begin
      e[i] = 0;
      if (!m[i]) begin
        x = c[i] - mx;
        if (x < -128) x = -128;
        xq.push_back(DW'(x));
        e[i] = 2048 >> (-x);
        sum += e[i];
      end
    end
    den_m = SW'(sum);
    sum0  = (sum == 0);
    for (int i = 0; i < N; i++) begin
      a = (sum == 0 || m[i]) ? 0 : (e[i] * 128) / sum;
      alpha_m[(N-1-i)*DW +: DW] = DW'(a);
      if (sum != 0 && !m[i]) numq.push_back(EW'(e[i]));
    end
  endtask

  // Compare process: samples mid-cycle, after the negedge drivers have settled.
  initial begin : compare
    int nphase;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (rst) begin
        phase = 0;
        xq.delete();
        numq.delete();
        prev_valid = 1'b0;
      end else begin
        nphase = phase;
        check("sm_ready", sm_ready_o, phase == 0);
        if (exp_req_o) begin
          if (xq.size() == 0) check("exp_req_unexpected", exp_req_o, 0);
          else begin
            check("exp_x", exp_x_o, xq[0]);
            if (exp_ack_i) begin
              xlog.push_back(exp_x_o);
              void'(xq.pop_front());
              exp_hs++;
            end
          end
        end
        if (div_req_o) begin
          if (numq.size() == 0 || xq.size() != 0) check("div_req_unexpected", div_req_o, 0);
          else begin
            check("div_num", div_num_o, numq[0]);
            check("div_den", div_den_o, den_m);
            if (div_ack_i) begin
              void'(numq.pop_front());
              div_hs++;
              last_den = div_den_o;
              last_div_cyc = cyc;
              if (numq.size() == 0) nphase = 2;
            end
          end
        end
        if (phase != 1) check("alpha_valid", alpha_valid_o, phase == 2);
        else if (alpha_valid_o) begin
          if (sum0 && xq.size() == 0) nphase = 2;
          else check("alpha_valid_early", alpha_valid_o, 0);
        end
        if (alpha_valid_o && phase != 0) begin
          check("alpha_o", alpha_o, alpha_m);
          if (!prev_valid) valid_cyc = cyc;
          if (alpha_ready_i) begin
            hs_cnt++;
            hs_cyc = cyc;
            last_alpha = alpha_o;
            nphase = 0;
          end
        end
        prev_valid = alpha_valid_o;
        if (sm_ready_o && sm_valid_i) begin
          if (row_q.size() == 0) check("capture_unexpected", sm_valid_i, 0);
          else begin
            build_model(row_q.pop_front(), rmask_q.pop_front());
            cap_cnt++;
            cap_cyc = cyc;
            nphase = 1;
          end
        end
        phase = nphase;
      end
    end
  end

  // Exponent and divider responders with optional random latency.
  initial begin : exp_resp
    int left;
    bit armed;
    armed = 1'b0;
    left = 0;
    forever begin
      @(negedge clk);
      exp_ack_i = 1'b0;
      if (exp_req_o) begin
        if (!armed) begin
          armed = 1'b1;
          left = rand_dly ? int'($urandom_range(0, 7)) : 0;
        end
        if (left == 0) begin
          exp_ack_i = 1'b1;
          exp_y_i = exp_unit(exp_x_o);
          armed = 1'b0;
        end else left--;
      end else armed = 1'b0;
    end
  end

  initial begin : div_resp
    int left;
    bit armed;
    armed = 1'b0;
    left = 0;
    forever begin
      @(negedge clk);
      div_ack_i = 1'b0;
      if (div_req_o) begin
        if (!armed) begin
          armed = 1'b1;
          left = rand_dly ? int'($urandom_range(0, 7)) : 0;
        end
        if (left == 0) begin
          div_ack_i = 1'b1;
          div_q_i = div_unit(div_num_o, div_den_o);
          armed = 1'b0;
        end else left--;
      end else armed = 1'b0;
    end
  end

  task automatic wait_cap(input int target);
    for (int k = 0; k < 400 && cap_cnt < target; k++) @(negedge clk);
    check("capture_timeout", cap_cnt >= target, 1);
  endtask

  task automatic wait_hs(input int target);
    for (int k = 0; k < 600 && hs_cnt < target; k++) @(negedge clk);
    check("handshake_timeout", hs_cnt >= target, 1);
  endtask

  task automatic send_row(input logic [N*DW-1:0] r, input logic [N-1:0] m);
    int c0;
    @(negedge clk);
    c0 = cap_cnt;
    row_q.push_back(r);
    rmask_q.push_back(m);
    coef_i = r;
    mask_i = m;
    sm_valid_i = 1'b1;
    wait_cap(c0 + 1);
    sm_valid_i = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_sm_ready", sm_ready_o, 1);
    check("rst_exp_req", exp_req_o, 0);
    check("rst_exp_x", exp_x_o, 0);
    check("rst_div_req", div_req_o, 0);
    check("rst_div_num", div_num_o, 0);
    check("rst_div_den", div_den_o, 0);
    check("rst_alpha_valid", alpha_valid_o, 0);
    check("rst_alpha_o", alpha_o, 0);
  endtask

  logic [DW-1:0] x_ref [5] = '{8'h00, 8'hFE, 8'h80, 8'h00, 8'hFD};

  initial begin : main
    int be, bd, bh, bc;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #3;
    check_reset_outputs();

    // All-zero row.
    be = exp_hs; bd = div_hs; bh = hs_cnt;
    send_row('0, '0);
    wait_hs(bh + 1);
    check("r0_exp_count", exp_hs - be, 5);
    check("r0_div_count", div_hs - bd, 5);
    check("r0_den", last_den, 10240);
    check("r0_alpha", last_alpha, 40'h19_19_19_19_19);
    check("r0_valid_latency", valid_cyc - last_div_cyc, 1);

    // Mixed row with a saturating difference.
    xlog.delete();
    bh = hs_cnt;
    send_row(40'h03_01_80_03_00, '0);
    wait_hs(bh + 1);
    check("r1_exp_count", xlog.size(), 5);
    for (int i = 0; i < 5 && i < xlog.size(); i++) check("r1_exp_x_seq", xlog[i], x_ref[i]);
    check("r1_alpha", last_alpha, 40'h35_0D_00_35_06);

    // Random unit latencies, downstream stalls for 10 cycles.
    rand_dly = 1'b1;
    alpha_ready_i = 1'b0;
    bh = hs_cnt;
    send_row(40'h05_04_06_02_06, '0);
    for (int k = 0; k < 600 && !alpha_valid_o; k++) @(negedge clk);
    check("r2_valid_seen", alpha_valid_o, 1);
    repeat (10) @(negedge clk);
    alpha_ready_i = 1'b1;
    wait_hs(bh + 1);
    check("r2_alpha", last_alpha, 40'h16_0B_2D_02_2D);
    rand_dly = 1'b0;

    // Reset in the middle of EXP, coinciding with an exponent ack.
    be = exp_hs;
    send_row(40'h07_01_02_03_04, '0);
    for (int k = 0; k < 100 && exp_hs < be + 2; k++) @(negedge clk);
    rst = 1'b1;
    #3;
    check("rst_ack_overlap", exp_ack_i & exp_req_o, 1);
    @(negedge clk);
    rst = 1'b0;
    #3;
    check_reset_outputs();
    bh = hs_cnt;
    send_row(40'h10_20_30_40_50, '0);
    wait_hs(bh + 1);
    check("r3_alpha", last_alpha, 40'h00_00_00_00_80);

    // Back-to-back rows with sm_valid_i held high.
    bh = hs_cnt; bc = cap_cnt;
    @(negedge clk);
    row_q.push_back(40'hFF_FE_FD_FC_FB);
    rmask_q.push_back('0);
    coef_i = 40'hFF_FE_FD_FC_FB;
    mask_i = '0;
    sm_valid_i = 1'b1;
    wait_cap(bc + 1);
    row_q.push_back('0);
    rmask_q.push_back('0);
    coef_i = '0;
    wait_cap(bc + 2);
    sm_valid_i = 1'b0;
    check("b2b_gap", cap_cyc - hs_cyc, 1);
    check("b2b_first_alpha", last_alpha, 40'h42_21_10_08_04);
    wait_hs(bh + 2);
    check("b2b_second_alpha", last_alpha, 40'h19_19_19_19_19);

`ifdef SOFTMAX_CTRL_MASK_EN
    be = exp_hs; bd = div_hs; bh = hs_cnt;
    send_row(40'h01_02_03_04_05, 5'b11111);
    wait_hs(bh + 1);
    check("mask_all_exp", exp_hs - be, 0);
    check("mask_all_div", div_hs - bd, 0);
    check("mask_all_alpha", last_alpha, 0);

    be = exp_hs; bh = hs_cnt;
    send_row('0, 5'b10001);
    wait_hs(bh + 1);
    check("mask_edge_exp", exp_hs - be, 3);
    check("mask_edge_alpha", last_alpha, 40'h00_2A_2A_2A_00);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
